// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default word parameters for the SPI slave shifter
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int IDLE_WORD_DEF = 'hFF;
endpackage

// File: rtl/spi_tx_holding_buf.sv
// spi_tx_holding_buf: single-entry tx word register; accepts on tx_valid&tx_ready, emptied by pop, same-cycle pop+accept keeps the new word
module spi_tx_holding_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] buf_data,
  output logic              buf_full
);
  logic accept;
  assign tx_ready = ~buf_full;
  assign accept = tx_valid & tx_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      buf_full <= accept ? 1'b1 : pop ? 1'b0 : buf_full;
      buf_data <= accept ? tx_data : buf_data;
    end
  end
endmodule

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: mode-0 SPI slave shifter on clk-domain sck/cs edge pulses; mosi->rx_data/rx_valid, tx_data/tx_valid/tx_ready->miso/miso_oe, tx_underrun/frame_abort status pulses
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck_rise,
  input  logic              sck_fall,
  input  logic              cs_fall,
  input  logic              cs_rise,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_n;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_next, tx_next, buf_data, load_word;
  logic reload_pending, buf_full, active, cs_evt, rise, fall, load, shift, last_bit;
  spi_tx_holding_buf #(.DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .pop(load),
    .buf_data(buf_data),
    .buf_full(buf_full)
  );
  always_comb begin
    state_n = state;
    state_n = cs_rise ? IDLE : cs_fall ? ACTIVE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  assign active = state == ACTIVE;
  assign cs_evt = cs_rise | cs_fall;
  assign rise = active & sck_rise & ~sck_fall & ~cs_evt;
  assign fall = active & sck_fall & ~sck_rise & ~cs_evt;
  assign load = (cs_fall & ~cs_rise) | (fall & reload_pending);
  assign shift = fall & ~reload_pending;
  assign last_bit = bit_cnt == CW'(DATA_W - 1);
  assign load_word = buf_full ? buf_data : IDLE_WORD;
  assign rx_next = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi} : {mosi, rx_shift[DATA_W-1:1]};
  assign tx_next = load ? load_word : MSB_FIRST ? tx_shift << 1 : tx_shift >> 1;
  assign miso = active & (MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0]);
  assign miso_oe = active;
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      reload_pending <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      tx_underrun    <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      bit_cnt        <= cs_evt ? '0 : rise ? (last_bit ? '0 : bit_cnt + 1'b1) : bit_cnt;
      rx_shift       <= cs_evt ? '0 : rise ? rx_next : rx_shift;
      tx_shift       <= (load | shift) ? tx_next : tx_shift;
      reload_pending <= cs_evt ? 1'b0 : (rise & last_bit) ? 1'b1 : load ? 1'b0 : reload_pending;
      rx_data        <= (rise & last_bit) ? rx_next : rx_data;
      rx_valid       <= rise & last_bit;
      tx_underrun    <= load & ~buf_full;
      frame_abort    <= cs_rise & active & (bit_cnt != '0);
    end
  end
endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: directed self-checking bench for spi_slave_shifter (DATA_W=8, MSB first)
module tb_spi_slave_shifter;
  logic clk = 1'b0;
  logic reset, sck_rise, sck_fall, cs_fall, cs_rise, mosi, miso, miso_oe;
  logic tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [7:0] tx_data, rx_data, miso_word;
  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt, un_cnt;
  logic rv_last, fa, un_start;
  always #5 clk = ~clk;
  spi_slave_shifter dut (
    .clk(clk),
    .reset(reset),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_fall(cs_fall),
    .cs_rise(cs_rise),
    .mosi(mosi),
    .miso(miso),
    .miso_oe(miso_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_underrun(tx_underrun),
    .frame_abort(frame_abort)
  );
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
  endtask
  task automatic frame_start;
    cs_fall = 1'b1;
    tick;
    cs_fall = 1'b0;
    un_start = tx_underrun;
    rv_cnt = 0;
    un_cnt = 0;
  endtask
  task automatic end_frame;
    cs_rise = 1'b1;
    tick;
    cs_rise = 1'b0;
    fa = frame_abort;
    tick;
  endtask
  task automatic xfer_bits(input logic [7:0] m, input int n);
    miso_word = '0;
    rv_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      miso_word[7-k] = miso;
      mosi = m[7-k];
      sck_rise = 1'b1;
      tick;
      sck_rise = 1'b0;
      rv_cnt += int'(rx_valid);
      rv_last = rx_valid;
      tick;
      sck_fall = 1'b1;
      tick;
      sck_fall = 1'b0;
      un_cnt += int'(tx_underrun);
      tick;
    end
  endtask
  initial begin
    reset = 1'b1; sck_rise = 0; sck_fall = 0; cs_fall = 0; cs_rise = 0;
    mosi = 0; tx_valid = 0; tx_data = '0; rv_cnt = 0; un_cnt = 0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_abort", frame_abort, 0);
    push(8'hA5);
    chk("t1_ready_full", tx_ready, 0);
    frame_start;
    chk("t1_oe", miso_oe, 1);
    chk("t1_un_start", un_start, 0);
    chk("t1_first_bit", miso, 1);
    chk("t1_ready_popped", tx_ready, 1);
    xfer_bits(8'h3C, 8);
    chk("t1_miso_word", miso_word, 8'hA5);
    chk("t1_rv_last", rv_last, 1);
    chk("t1_rv_cnt", rv_cnt, 1);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_un_boundary", un_cnt, 1);
    end_frame;
    chk("t1_clean_end", fa, 0);
    chk("t1_oe_off", miso_oe, 0);
    chk("t1_miso_off", miso, 0);
    frame_start;
    chk("t2_un_start", un_start, 1);
    xfer_bits(8'h00, 8);
    chk("t2_miso_word", miso_word, 8'hFF);
    chk("t2_rx_data", rx_data, 8'h00);
    end_frame;
    push(8'h11);
    frame_start;
    push(8'h22);
    chk("t3_ready_full", tx_ready, 0);
    xfer_bits(8'hAA, 8);
    chk("t3_miso_w1", miso_word, 8'h11);
    chk("t3_rx_w1", rx_data, 8'hAA);
    xfer_bits(8'h55, 8);
    chk("t3_miso_w2", miso_word, 8'h22);
    chk("t3_rx_w2", rx_data, 8'h55);
    chk("t3_rv_cnt", rv_cnt, 2);
    chk("t3_un_cnt", un_cnt, 1);
    end_frame;
    chk("t3_clean_end", fa, 0);
    frame_start;
    xfer_bits(8'hF0, 5);
    end_frame;
    chk("t4_abort", fa, 1);
    chk("t4_rv_cnt", rv_cnt, 0);
    chk("t4_rx_data", rx_data, 8'h55);
    chk("t4_oe", miso_oe, 0);
    frame_start;
    xfer_bits(8'h0F, 7);
    mosi = 1'b1;
    sck_rise = 1'b1;
    cs_rise = 1'b1;
    tick;
    sck_rise = 1'b0;
    cs_rise = 1'b0;
    chk("t5_abort", frame_abort, 1);
    chk("t5_rx_valid", rx_valid, 0);
    tick;
    chk("t5_rx_data", rx_data, 8'h55);
    chk("t5_oe", miso_oe, 0);
    push(8'h96);
    frame_start;
    xfer_bits(8'hFF, 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_oe", miso_oe, 0);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_ready", tx_ready, 1);
    frame_start;
    chk("t6_un_start", un_start, 1);
    xfer_bits(8'h81, 8);
    chk("t6_rx_data_new", rx_data, 8'h81);
    chk("t6_rv_cnt", rv_cnt, 1);
    end_frame;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    cs_fall = 1'b1;
    tick;
    tx_valid = 1'b0;
    cs_fall = 1'b0;
    rv_cnt = 0;
    un_cnt = 0;
    chk("t7_un_start", tx_underrun, 1);
    chk("t7_ready_full", tx_ready, 0);
    sck_rise = 1'b1;
    sck_fall = 1'b1;
    tick;
    sck_rise = 1'b0;
    sck_fall = 1'b0;
    tick;
    xfer_bits(8'h00, 8);
    chk("t7_miso_idle", miso_word, 8'hFF);
    xfer_bits(8'hC3, 8);
    chk("t7_miso_new", miso_word, 8'h5A);
    chk("t7_rx_data", rx_data, 8'hC3);
    chk("t7_rv_cnt", rv_cnt, 2);
    end_frame;
    chk("t7_clean_end", fa, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
